cory_pipe_buf: RTL and testbench
================================

Name: cory_pipe_buf

Overview:
- Parametrised D-entry valid/ready buffer; generalises the single-flop stage to arbitrary width N and depth D.
- Exposes an occupancy count and a selectable ready-timing mode.
- Sits between producer/consumer stages wherever more than one entry of elasticity is needed (latency absorption, credit smoothing).
- Storage is flops, arranged as a circular buffer with read/write pointers.

Parameters:
- N, 8, data width in bits; must be >= 1.
- D, 4, number of entries; must be >= 1; need not be a power of 2.
- SPEED, 0, 0 = ready propagates combinationally from i_z_r; 1 = o_a_r is purely registered (no r->r path).

Ports:
- clk  input  1  clock.
- reset_n  input  1  async reset, active-low.
- i_a_v  input  1  upstream valid.
- i_a_d  input  N  upstream data.
- o_a_r  output  1  upstream ready.
- o_z_v  output  1  downstream valid.
- o_z_d  output  N  downstream data, head entry.
- i_z_r  input  1  downstream ready.
- o_cnt  output  CW=$clog2(D+1)  current occupancy, 0..D.
- i_flush  input  1  synchronous flush; present only with CORY_PIPE_BUF_FLUSH_EN.

Behaviour:
- Clocking and reset: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - all storage = 0; wr_ptr = rd_ptr = 0; cnt = 0.
  - outputs: o_z_v = 0, o_z_d = 0, o_cnt = 0, o_a_r = 1.
- Handshakes:
  - push = i_a_v & o_a_r; pop = o_z_v & i_z_r.
  - Data is transferred only on cycles where the respective handshake is high.
- Outputs:
  - o_z_v = (cnt != 0).
  - o_z_d = mem[rd_ptr], driven directly from flops.
  - o_cnt = cnt, registered.
- Latency: data pushed in cycle t appears at o_z_* in cycle t+1 at the earliest. There is no combinational bypass: with cnt = 0, o_z_v stays 0 in the push cycle.
- Ready, SPEED=0: o_a_r = (cnt != D) | pop. When full, a same-cycle pop frees a slot, giving 100% throughput at D=1.
- Ready, SPEED=1: o_a_r = (cnt != D). At D=1 throughput is 50%; for D >= 2 steady-state throughput is 100%.
- Push: mem[wr_ptr] <= i_a_d. wr_ptr advances by 1 and wraps from D-1 to 0.
- Pop: rd_ptr advances by 1 and wraps from D-1 to 0.
- Count update:
  - push & !pop: cnt + 1.
  - !push & pop: cnt - 1.
  - both or neither: unchanged.
- Boundaries:
  - cnt never exceeds D and never underflows.
  - full with a simultaneous push & pop (SPEED=0 only): cnt stays D and the pointers both advance.
  - empty: o_z_d holds stale data while o_z_v = 0; no pop can occur.
- i_a_d is sampled only on push; o_z_d is stable while o_z_v & !i_z_r.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); in-flight entries are discarded.
- SIM builds: a D or N value of 0 prints an error and calls $finish.

Optional Feature:
- Macro: CORY_PIPE_BUF_FLUSH_EN.
- Defined: the i_flush port exists.
  - While i_flush = 1, o_a_r is forced to 0, so no push occurs.
  - o_z_v and pop still behave normally during the flush cycle.
  - On the next edge, cnt, wr_ptr and rd_ptr are set to 0; storage contents are not cleared.
  - Flush overrides any same-cycle pop for count purposes (cnt becomes 0).
- Undefined: the i_flush port is absent and the block behaves exactly as specified above.

Test Plan:
- Reset, then idle: o_a_r=1, o_z_v=0, o_cnt=0, o_z_d=0 for 10 cycles.
- D=4, SPEED=0, i_z_r=0, push 0x11,0x22,0x33,0x44 back-to-back -> o_cnt 1..4, o_a_r=0 once cnt=4. Then i_z_r=1 -> 0x11,0x22,0x33,0x44 out in order, one per cycle.
- D=1, SPEED=0, continuous valid and ready, data 0..15 -> one transfer per cycle after the first, output sequence 0..15, o_cnt stays 1. Same with SPEED=1 -> one transfer every 2 cycles.
- D=3 (non-power-of-2), 20 pushes with random i_z_r -> output order equals input order across pointer wrap; o_cnt matches the model every cycle.
- D=4 full with i_a_v=1 and i_z_r=1 -> SPEED=0: push and pop in the same cycle, cnt stays 4. SPEED=1: o_a_r=0 that cycle, cnt drops to 3.
- CORY_PIPE_BUF_FLUSH_EN, cnt=3, pulse i_flush with i_a_v=1 -> o_a_r=0 during the pulse, o_cnt=0 and o_z_v=0 next cycle. Then push 0x5A -> 0x5A is the next output. Also assert reset_n low mid-stream -> outputs return to reset values immediately.

Source files
------------

// File: rtl/cory_pipe_buf.sv
// D-entry valid/ready elastic buffer (flop circular buffer) with occupancy count.
// Optional synchronous flush when CORY_PIPE_BUF_FLUSH_EN is defined.
module cory_pipe_buf #(
  parameter int N     = 8,
  parameter int D     = 4,
  parameter int SPEED = 0,
  localparam int CW   = $clog2(D + 1),
  localparam int PW   = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_a_v,
  input  logic [N-1:0]  i_a_d,
  output logic          o_a_r,
  output logic          o_z_v,
  output logic [N-1:0]  o_z_d,
  input  logic          i_z_r,
`ifdef CORY_PIPE_BUF_FLUSH_EN
  input  logic          i_flush,
`endif
  output logic [CW-1:0] o_cnt
);

  if (N < 1 || D < 1) begin : g_bad_param
    $error("cory_pipe_buf: N and D must both be >= 1");
  end

  logic [N-1:0]  r_mem [D];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;

  logic w_flush;
  logic w_full;
  logic w_push;
  logic w_pop;

`ifdef CORY_PIPE_BUF_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full = (r_cnt == CW'(D));
  assign o_z_v  = (r_cnt != '0);
  assign o_z_d  = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;
  assign w_pop  = o_z_v & i_z_r;
  assign w_push = i_a_v & o_a_r;

  // SPEED=1 trades D=1 throughput for a ready with no path from i_z_r.
  if (SPEED != 0) begin : g_rdy_reg
    assign o_a_r = ~w_full & ~w_flush;
  end else begin : g_rdy_comb
    assign o_a_r = (~w_full | w_pop) & ~w_flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < D; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_a_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (w_flush) begin
      // Flush wins over a same-cycle pop; storage is left as-is.
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(D - 1)) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(D - 1)) ? '0 : r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cory_pipe_buf.sv
// Bench for cory_pipe_buf: five configurations driven in parallel against a queue model.
module tb_cory_pipe_buf;

  localparam int NI = 5;
  localparam int DS [NI] = '{4, 1, 1, 3, 4};
  localparam int SS [NI] = '{0, 0, 1, 0, 1};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_v = 1'b0;
  logic       z_r = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] a_d [NI];
  logic       a_r [NI];
  logic       z_v [NI];
  logic [7:0] z_d [NI];
  logic [3:0] cnt [NI];

  int n_checks = 0;
  int n_errors = 0;
  int dmode = 0;                 // 0 random data, 1 per-instance sequence, 2 manual
  int seq [NI];
  int npush [NI];
  logic [7:0] q [NI][$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CWG = $clog2(DS[g] + 1);
    logic [CWG-1:0] w_cnt;
    cory_pipe_buf #(.N(8), .D(DS[g]), .SPEED(SS[g])) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .i_a_v   (a_v),
      .i_a_d   (a_d[g]),
      .o_a_r   (a_r[g]),
      .o_z_v   (z_v[g]),
      .o_z_d   (z_d[g]),
      .i_z_r   (z_r),
`ifdef CORY_PIPE_BUF_FLUSH_EN
      .i_flush (flush),
`endif
      .o_cnt   (w_cnt)
    );
    assign cnt[g] = 4'(w_cnt);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < NI; i++) begin
      if (dmode == 0)      a_d[i] = 8'($urandom);
      else if (dmode == 1) a_d[i] = 8'(seq[i]);
    end
  endtask

  // One clock: compare against the model mid-cycle, then advance the model.
  task automatic cycle();
    int  sz;
    bit  pop, rdy, push;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      sz   = q[i].size();
      pop  = (sz != 0) && z_r;
      rdy  = ((sz < DS[i]) || (SS[i] == 0 && pop)) && !flush;
      push = a_v && rdy;
      check_eq($sformatf("rdy%0d", i), 32'(a_r[i]), 32'(rdy));
      check_eq($sformatf("vld%0d", i), 32'(z_v[i]), 32'(sz != 0));
      check_eq($sformatf("cnt%0d", i), 32'(cnt[i]), 32'(sz));
      if (sz != 0) check_eq($sformatf("dat%0d", i), 32'(z_d[i]), 32'(q[i][0]));
      if (pop) void'(q[i].pop_front());
      if (push) begin
        q[i].push_back(a_d[i]);
        seq[i]++;
        npush[i]++;
      end
      if (flush) q[i].delete();
    end
    @(posedge clk);
    #1;
    set_data();
  endtask

  task automatic run(input int n, input logic v, input logic r);
    a_v = v;
    z_r = r;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("%s_rdy%0d", tag, i), 32'(a_r[i]), 32'd1);
      check_eq($sformatf("%s_vld%0d", tag, i), 32'(z_v[i]), 32'd0);
      check_eq($sformatf("%s_cnt%0d", tag, i), 32'(cnt[i]), 32'd0);
      check_eq($sformatf("%s_dat%0d", tag, i), 32'(z_d[i]), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      a_d[i] = '0;
      seq[i] = 0;
      npush[i] = 0;
    end
    #2;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Idle after reset.
    run(10, 1'b0, 1'b0);
    check_reset_outputs("idle");

    // Back-to-back fill with downstream stalled, then drain in order.
    dmode = 2;
    a_v = 1'b1;
    z_r = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < NI; i++) a_d[i] = 8'(k * 8'h11);
      cycle();
    end
    check_eq("fill_cnt", 32'(cnt[0]), 32'd4);
    check_eq("fill_rdy", 32'(a_r[0]), 32'd0);
    run(6, 1'b0, 1'b1);

    // Continuous streaming of 0..15.
    dmode = 1;
    for (int i = 0; i < NI; i++) begin
      seq[i] = 0;
      npush[i] = 0;
    end
    set_data();
    run(16, 1'b1, 1'b1);
    check_eq("tput_d1_s0", 32'(npush[1]), 32'd16);
    check_eq("tput_d1_s1", 32'(npush[2]), 32'd8);
    run(6, 1'b0, 1'b1);

    // Random traffic, exercises pointer wrap at D=3.
    dmode = 0;
    set_data();
    for (int k = 0; k < 400; k++) begin
      a_v = ($urandom_range(0, 3) != 0);
      z_r = ($urandom_range(0, 2) != 0);
      cycle();
    end
    run(6, 1'b0, 1'b1);

    // Full with push and pop requested together.
    run(5, 1'b1, 1'b0);
    run(1, 1'b1, 1'b1);
    check_eq("full_pp_s0", 32'(cnt[0]), 32'd4);
    check_eq("full_pp_s1", 32'(cnt[4]), 32'd3);
    run(6, 1'b0, 1'b1);

`ifdef CORY_PIPE_BUF_FLUSH_EN
    run(3, 1'b1, 1'b0);
    check_eq("pre_flush_cnt", 32'(cnt[0]), 32'd3);
    flush = 1'b1;
    run(1, 1'b1, 1'b0);
    flush = 1'b0;
    check_eq("flush_cnt", 32'(cnt[0]), 32'd0);
    check_eq("flush_vld", 32'(z_v[0]), 32'd0);
    dmode = 2;
    for (int i = 0; i < NI; i++) a_d[i] = 8'h5A;
    run(1, 1'b1, 1'b0);
    check_eq("flush_next", 32'(z_d[0]), 32'h5A);
    dmode = 0;
    set_data();
    run(3, 1'b0, 1'b1);
`endif

    // Asynchronous reset mid-stream.
    run(3, 1'b1, 1'b0);
    a_v = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    for (int i = 0; i < NI; i++) q[i].delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(5, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
